// File: rtl/md_unit_param.sv
// Parametrised multiply/divide unit for the EX stage.
// The full 2*WIDTH result is computed at the start edge and parked in a
// pending register; a down-counter models the op latency and the pending
// value is committed to HI/LO on the 1 -> 0 counter transition.
module md_unit_param #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we,
    input  logic             sel,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int W2   = 2 * WIDTH;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    pend_q, pend_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    logic             sgn;
    logic             is_div;
    logic [W2-1:0]    ax, bx, prod, acc, res;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, b_den, uq, ur, q, r;
    logic             start_acc, commit;

    // Arithmetic: one wide multiply and one unsigned divide on magnitudes
    always_comb begin
        sgn    = ~op[0];
        is_div = (op[2:1] == 2'b01);
        ax     = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        bx     = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod   = ax * bx;
        acc    = {hi_q, lo_q};
        a_neg  = sgn & a[WIDTH-1];
        b_neg  = sgn & b[WIDTH-1];
        a_mag  = a_neg ? (~a + 1'b1) : a;
        b_mag  = b_neg ? (~b + 1'b1) : b;
        // Keep the divider away from a zero denominator; b==0 is overridden below.
        b_den  = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        uq     = a_mag / b_den;
        ur     = a_mag % b_den;
        q      = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
        r      = a_neg ? (~ur + 1'b1) : ur;
        if (b == '0) begin
            q = '1;
            r = a;
        end
        case (op[2:0])
            3'd0, 3'd1: res = prod;
            3'd2, 3'd3: res = {r, q};
            3'd4, 3'd5: res = acc + prod;
            default:    res = acc - prod;
        endcase
    end

    // Control: abort beats start, start beats we, commit on counter 1 -> 0
    always_comb begin
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        commit    = (cnt_q == CW'(1)) && !abort;
        start_acc = start && !op[3] && (cnt_q <= CW'(1)) && !abort;
        if (abort) begin
            cnt_d  = '0;
            pend_d = '0;
        end else begin
            if (cnt_q != '0)
                cnt_d = cnt_q - 1'b1;
            if (commit) begin
                {hi_d, lo_d} = pend_q;
                done_d       = 1'b1;
            end
            if (start_acc) begin
                pend_d = res;
                cnt_d  = is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            end else if (we && (cnt_q == '0)) begin
                if (sel) lo_d = a;
                else     hi_d = a;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit_param.sv
// Directed bench for md_unit_param with hand-computed expectations.
module tb_md_unit_param;

    logic        clk = 1'b0;
    logic        reset, start, we, sel, abort;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          nvec = 0;
    int          nfail = 0;

    md_unit_param #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .we(we), .sel(sel), .abort(abort), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch an op at a negedge and follow it through to commit.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input int n,
                          input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                          input logic [31:0] ehi, input logic [31:0] elo);
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0;
        check({tag, " hi held"}, {32'd0, hi}, {32'd0, pre_hi});
        check({tag, " lo held"}, {32'd0, lo}, {32'd0, pre_lo});
        for (int i = 0; i < n; i++) begin
            check({tag, " busy"}, {62'd0, busy, done}, 64'd2);
            @(negedge clk);
        end
        check({tag, " busy/done at commit"}, {62'd0, busy, done}, 64'd1);
        check({tag, " result"}, {hi, lo}, {ehi, elo});
        @(negedge clk);
        check({tag, " done one cycle"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; we = 1'b0; sel = 1'b0; abort = 1'b0;
        op = 4'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset state", {hi, lo}, 64'd0);
        check("reset flags", {62'd0, busy, done}, 64'd0);
        reset = 1'b0;

        // reserved op is ignored
        start = 1'b1; op = 4'd8; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        check("reserved op", {62'd0, busy, done}, 64'd0);

        run_op("MULT", 4'd0, 32'hFFFFFFFE, 32'd3, 5, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("DIVU by 0", 4'd3, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'd7, 32'hFFFFFFFF);
        run_op("DIV ovf", 4'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd7, 32'hFFFFFFFF, 32'd0, 32'h80000000);

        // MTHI 0, MTLO all-ones
        we = 1'b1; sel = 1'b0; a = 32'd0;
        @(negedge clk);
        sel = 1'b1; a = 32'hFFFFFFFF;
        @(negedge clk);
        we = 1'b0;
        check("MTHI/MTLO", {hi, lo}, 64'h00000000_FFFFFFFF);

        run_op("MADDU", 4'd5, 32'd1, 32'd1, 5, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0);
        run_op("MSUB", 4'd6, 32'd1, 32'd2, 5, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFE);

        // abort in cycle 3 of a MULT
        start = 1'b1; op = 4'd0; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy/done", {62'd0, busy, done}, 64'd0);
        check("abort hi/lo", {hi, lo}, 64'h00000000_FFFFFFFE);
        for (int i = 0; i < 6; i++) begin
            check("abort no done", {62'd0, busy, done}, 64'd0);
            @(negedge clk);
        end
        check("abort hi/lo later", {hi, lo}, 64'h00000000_FFFFFFFE);

        // we while busy is dropped
        start = 1'b1; op = 4'd0; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0; we = 1'b1; sel = 1'b1; a = 32'h1234;
        @(negedge clk);
        we = 1'b0;
        repeat (3) @(negedge clk);
        check("busy we lo pre", {32'd0, lo}, 64'hFFFFFFFE);
        @(negedge clk);
        check("busy we commit", {61'd0, busy, done, 1'b0}, 64'd2);
        check("busy we result", {hi, lo}, 64'd6);
        // idle we lands next cycle
        we = 1'b1; sel = 1'b1; a = 32'h1234;
        @(negedge clk);
        we = 1'b0;
        check("idle MTLO", {hi, lo}, 64'h00000000_00001234);

        // start and we together: start wins
        start = 1'b1; op = 4'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; we = 1'b1; sel = 1'b1;
        @(negedge clk);
        start = 1'b0; we = 1'b0;
        check("start beats we lo", {32'd0, lo}, 64'h1234);
        check("start beats we busy", {63'd0, busy}, 64'd1);
        repeat (5) @(negedge clk);
        check("MULTU done", {63'd0, done}, 64'd1);
        check("MULTU result", {hi, lo}, 64'hFFFFFFFE_00000001);

        // DIV launched on the commit edge of a MULT
        start = 1'b1; op = 4'd0; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 4'd2; a = 32'hFFFFFFF9; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        check("b2b commit flags", {62'd0, busy, done}, 64'd3);
        check("b2b MULT result", {hi, lo}, 64'd42);
        for (int i = 0; i < 10; i++) begin
            check("b2b DIV busy", {63'd0, busy}, 64'd1);
            @(negedge clk);
        end
        check("b2b DIV flags", {62'd0, busy, done}, 64'd1);
        check("b2b DIV result", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        // reset mid-op
        start = 1'b1; op = 4'd0; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midop reset hi/lo", {hi, lo}, 64'd0);
        check("midop reset flags", {62'd0, busy, done}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            check("midop reset no commit", {31'd0, done, lo}, 64'd0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
